cpu_sequencer: RTL

- Generates the 3-bit instruction phase that drives the CPU control decoder, and gates the datapath with a clock-enable.
- Adds run/stop/single-step debug control, a PC breakpoint and a retired-instruction counter.
- Sits between top-level debug/testbench inputs and the control decoder, replacing the free-running phase counter.

---
 rtl/cpu_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Instruction-phase generator with run/stop/single-step debug
//            control, PC breakpoint, HALT detection and a saturating
//            retired-instruction counter. Drives the control decoder phase
//            and the datapath clock-enable.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int AWIDTH       = 5,
    parameter int CNTW         = 16,
    parameter int RUN_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic [AWIDTH-1:0] pc_addr,
    input  logic              run_req,
    input  logic              stop_req,
    input  logic              step_req,
    input  logic              bp_en,
    input  logic [AWIDTH-1:0] bp_addr,
    output logic [2:0]        phase,
    output logic              cpu_en,
    output logic              running,
    output logic              halted,
    output logic              bp_hit,
    output logic [CNTW-1:0]   instr_count
);

    localparam logic [1:0]      c_S_IDLE    = 2'd0;
    localparam logic [1:0]      c_S_RUN     = 2'd1;
    localparam logic [1:0]      c_S_STEP    = 2'd2;
    localparam logic [1:0]      c_S_HALTED  = 2'd3;

    localparam logic [2:0]      c_PH_FIRST  = 3'd0;
    localparam logic [2:0]      c_PH_SKIP   = 3'd1;
    localparam logic [2:0]      c_PH_HALT   = 3'd4;
    localparam logic [2:0]      c_PH_LAST   = 3'd7;

    localparam logic [CNTW-1:0] c_CNT_MAX   = {CNTW{1'b1}};

    logic [1:0]      r_state;
    logic [2:0]      r_phase;
    logic            r_halted;
    logic            r_bp_hit;
    logic [CNTW-1:0] r_count;
    logic            r_stop_pend;
    logic            r_bp_skip;
    logic            r_boot;      // high for the first clock after reset release

    logic            w_active;
    logic            w_halt_take;
    logic            w_bp_take;

    // Datapath is enabled only while an instruction is actually executing
    assign w_active    = (r_state == c_S_RUN) || (r_state == c_S_STEP);

    // HALT is only meaningful in the decode phase of an executing instruction
    assign w_halt_take = w_active && halt && (r_phase == c_PH_HALT);

    // Breakpoint fires before the instruction at bp_addr starts, unless we are
    // resuming from that very breakpoint
    assign w_bp_take   = w_active && bp_en && (r_phase == c_PH_FIRST) &&
                         (pc_addr == bp_addr) && !r_bp_skip;

    // Sequencer state, phase counter, sticky flags and retired-instruction count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_phase     <= 3'd0;
            r_halted    <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_count     <= '0;
            r_stop_pend <= 1'b0;
            r_bp_skip   <= 1'b0;
            r_boot      <= 1'b1;
        end else begin
            r_boot <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_phase <= 3'd0;
                    if ((r_boot && (RUN_ON_RESET != 0)) || run_req) begin
                        r_state     <= c_S_RUN;
                        r_bp_hit    <= 1'b0;
                        r_stop_pend <= 1'b0;
                        r_bp_skip   <= r_bp_hit;
                    end else if (step_req) begin
                        r_state     <= c_S_STEP;
                        r_bp_hit    <= 1'b0;
                        r_stop_pend <= 1'b0;
                        r_bp_skip   <= r_bp_hit;
                    end
                end

                c_S_HALTED: begin
                    r_phase <= 3'd0;
                    if (run_req) begin
                        r_state  <= c_S_RUN;
                        r_halted <= 1'b0;
                    end else if (step_req) begin
                        r_state  <= c_S_STEP;
                        r_halted <= 1'b0;
                    end
                end

                c_S_RUN, c_S_STEP: begin
                    if (w_halt_take) begin
                        // HALT outranks stop, breakpoint and step completion
                        r_state     <= c_S_HALTED;
                        r_halted    <= 1'b1;
                        r_phase     <= 3'd0;
                        r_stop_pend <= 1'b0;
                    end else if (w_bp_take) begin
                        // Stop without advancing; the instruction is not run
                        r_state     <= c_S_IDLE;
                        r_bp_hit    <= 1'b1;
                        r_phase     <= 3'd0;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_phase <= r_phase + 3'd1;
                        if (r_phase == c_PH_SKIP) begin
                            r_bp_skip <= 1'b0;
                        end
                        if ((r_state == c_S_RUN) && stop_req) begin
                            r_stop_pend <= 1'b1;
                        end
                        if (r_phase == c_PH_LAST) begin
                            if (r_count != c_CNT_MAX) begin
                                r_count <= r_count + CNTW'(1);
                            end
                            if ((r_state == c_S_STEP) || r_stop_pend) begin
                                r_state     <= c_S_IDLE;
                                r_stop_pend <= 1'b0;
                                r_phase     <= 3'd0;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                    r_phase <= 3'd0;
                end
            endcase
        end
    end

    assign phase       = r_phase;
    assign cpu_en      = w_active;
    assign running     = w_active;
    assign halted      = r_halted;
    assign bp_hit      = r_bp_hit;
    assign instr_count = r_count;

endmodule
`default_nettype wire
